// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants for the ALU sequencer and its ALU.
// Opcodes are 3 bits wide. ST and LD are pass-through operations.
package alu_sequencer_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_LD  = 3'd6;
    localparam logic [OP_W-1:0] OP_ST  = 3'd7;

    // Only the arithmetic opcodes are allowed to touch the carry flag.
    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU with clock-enable gating.
// For non-arithmetic ops, carry_in passes through to carry_out unchanged.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic              ce,
    input  logic [OP_W-1:0]   op,
    input  logic [SIZE-1:0]   op_a,
    input  logic [SIZE-1:0]   op_b,
    input  logic              carry_in,
    output logic [SIZE-1:0]   op_out,
    output logic              carry_out
);

    logic [SIZE:0] sum;
    logic [SIZE:0] diff;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        op_out    = '0;
        carry_out = 1'b0;
        if (ce) begin
            carry_out = carry_in;
            unique case (op)
                OP_ADD: begin
                    op_out    = sum[SIZE-1:0];
                    carry_out = sum[SIZE];
                end
                // The wrapped top bit of the difference is the borrow.
                OP_SUB: begin
                    op_out    = diff[SIZE-1:0];
                    carry_out = diff[SIZE];
                end
                OP_AND:  op_out = op_a & op_b;
                OP_OR:   op_out = op_a | op_b;
                OP_XOR:  op_out = op_a ^ op_b;
                OP_NOT:  op_out = ~op_a;
                OP_LD:   op_out = op_b;
                OP_ST:   op_out = op_a;
                default: op_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction at a time over an inline register file.
// Each instruction goes IDLE -> EXEC -> WB -> RESP, then waits for the result handshake.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int NREGS = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [OP_W-1:0]          instr_op,
    input  logic [$clog2(NREGS)-1:0] instr_rd,
    input  logic [$clog2(NREGS)-1:0] instr_rs,
    input  logic                     instr_imm_en,
    input  logic [SIZE-1:0]          instr_imm,
    input  logic                     reg_wr_en,
    input  logic [$clog2(NREGS)-1:0] reg_wr_addr,
    input  logic [SIZE-1:0]          reg_wr_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SIZE-1:0]          res_data,
    output logic                     res_carry,
    output logic                     busy
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [SIZE-1:0]   regs [NREGS];
    logic [OP_W-1:0]   op_q;
    logic [AW-1:0]     rd_q;
    logic [SIZE-1:0]   left_q;
    logic [SIZE-1:0]   right_q;
    logic [SIZE-1:0]   result_q;
    logic              carry_q;

    logic              accept;
    logic              alu_ce;
    logic [SIZE-1:0]   alu_out;
    logic              alu_carry;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        alu_ce      = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                // A preload in the same cycle holds off the instruction.
                instr_ready = !reg_wr_en;
                if (instr_valid && !reg_wr_en) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                alu_ce   = 1'b1;
                state_nx = WB;
            end
            WB: begin
                state_nx = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign res_data  = (state == RESP) ? result_q : '0;
    assign res_carry = carry_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            op_q     <= '0;
            rd_q     <= '0;
            left_q   <= '0;
            right_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && reg_wr_en) begin
                regs[reg_wr_addr] <= reg_wr_data;
            end
            // Operands are read here, so rd==rs sees the value before writeback.
            if (accept) begin
                op_q    <= instr_op;
                rd_q    <= instr_rd;
                left_q  <= regs[instr_rd];
                right_q <= instr_imm_en ? instr_imm : regs[instr_rs];
            end
            if (alu_ce) begin
                result_q <= alu_out;
                carry_q  <= alu_carry;
            end
            if ((state == WB) && (op_q != OP_ST)) begin
                regs[rd_q] <= result_q;
            end
        end
    end

    alu_sequencer_alu #(
        .SIZE(SIZE)
    ) u_alu (
        .ce        (alu_ce),
        .op        (op_q),
        .op_a      (left_q),
        .op_b      (right_q),
        .carry_in  (carry_q),
        .op_out    (alu_out),
        .carry_out (alu_carry)
    );

endmodule
